// File: rtl/atari_video_pkg.sv
// Shared constants and types for the Atari video path (TIA capture to VGA scan-out).
package atari_video_pkg;

  localparam int COLOR_W      = 7;
  localparam int TIA_PIXELS   = 160;
  localparam int VGA_H_ACTIVE = 640;
  localparam int HSHIFT       = 2;

  typedef logic [COLOR_W-1:0] color_t;

endpackage

// File: rtl/tia_scanline_doubler_if.sv
// Bundle of TIA write-side, VGA read-side and status signals for the scanline doubler.
// Handshake: no valid/ready back-pressure; tia_wr_en qualifies tia_xpos/tia_color in the
// cycle it is high, pix_valid qualifies pix_color in the cycle it is high, both always accepted.
interface tia_scanline_doubler_if;
  import atari_video_pkg::*;

  logic         tia_wr_en;
  logic [7:0]   tia_xpos;
  color_t       tia_color;
  logic         tia_line_start;
  logic [9:0]   vga_hpos;
  logic [9:0]   vga_vpos;
  logic         vga_line_start;
  color_t       pix_color;
  logic         pix_valid;
  logic         line_drop;
  logic         dbg_wr_bank;
  logic         dbg_rd_bank;
  logic [1:0]   dbg_bank_valid;

  modport master (
    output tia_wr_en, tia_xpos, tia_color, tia_line_start,
           vga_hpos, vga_vpos, vga_line_start,
    input  pix_color, pix_valid, line_drop,
           dbg_wr_bank, dbg_rd_bank, dbg_bank_valid
  );

  modport slave (
    input  tia_wr_en, tia_xpos, tia_color, tia_line_start,
           vga_hpos, vga_vpos, vga_line_start,
    output pix_color, pix_valid, line_drop,
           dbg_wr_bank, dbg_rd_bank, dbg_bank_valid
  );

endinterface

// File: rtl/line_ram_2bank.sv
// Two-bank line buffer: one synchronous write port, one registered read port, write-first on match.
module line_ram_2bank
  import atari_video_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic       wr_bank,
  input  logic [7:0] wr_addr,
  input  color_t     wr_data,
  input  logic       rd_en,
  input  logic       rd_bank,
  input  logic [7:0] rd_addr,
  output color_t     rd_data
);

  color_t mem [0:1][0:TIA_PIXELS-1];
  color_t rd_data_q;
  color_t rd_data_d;

  // rd_en low forces a zero word so the output register doubles as the blanking stage.
  always_comb begin
    rd_data_d = '0;
    if (rd_en) begin
      if (wr_en && (wr_bank == rd_bank) && (wr_addr == rd_addr)) begin
        rd_data_d = wr_data;
      end else begin
        rd_data_d = mem[rd_bank][rd_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/tia_scanline_doubler.sv
// Captures TIA scanlines into a ping-pong buffer and replays the last complete line
// to VGA at 4x horizontal / 2x vertical scale, flagging lines lost to rate mismatch.
module tia_scanline_doubler
  import atari_video_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  tia_scanline_doubler_if.slave  bus
);

  localparam logic [7:0] PIX_LIMIT = 8'(TIA_PIXELS);
  localparam logic [9:0] H_LIMIT   = 10'(VGA_H_ACTIVE);

  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic [1:0] bank_valid_q, bank_valid_d;
  logic [1:0] drop_cnt_q, drop_cnt_d;
  logic       line_drop_q, line_drop_d;
  logic       pix_valid_q, pix_valid_d;

  logic       eff_wr_bank;
  logic       wr_accept;
  logic       even_latch;
  logic       rd_en;
  logic [7:0] rd_addr;
  color_t     rd_data;

  always_comb begin
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    bank_valid_d = bank_valid_q;
    drop_cnt_d   = drop_cnt_q;
    eff_wr_bank  = wr_bank_q ^ bus.tia_line_start;
    wr_accept    = bus.tia_wr_en && (bus.tia_xpos < PIX_LIMIT);
    even_latch   = bus.vga_line_start && !bus.vga_vpos[0];

    if (bus.tia_line_start) begin
      wr_bank_d                 = eff_wr_bank;
      bank_valid_d[eff_wr_bank] = 1'b0;
    end
    if (wr_accept) begin
      bank_valid_d[eff_wr_bank] = 1'b1;
    end

    // The latch sees the pre-toggle write bank, i.e. the most recently finished line.
    if (even_latch) begin
      rd_bank_d = ~wr_bank_q;
    end

    // A TIA pulse coincident with the even latch belongs to the new VGA pair.
    if (even_latch) begin
      drop_cnt_d = bus.tia_line_start ? 2'd1 : 2'd0;
    end else if (bus.tia_line_start && (drop_cnt_q != 2'd2)) begin
      drop_cnt_d = drop_cnt_q + 2'd1;
    end
    line_drop_d = line_drop_q || (drop_cnt_d == 2'd2);

    // Read from the freshly latched bank so pixel 0 of an even line is already correct.
    rd_addr     = 8'(bus.vga_hpos >> HSHIFT);
    rd_en       = (bus.vga_hpos < H_LIMIT) && bank_valid_q[rd_bank_d];
    pix_valid_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b1;
      bank_valid_q <= 2'b00;
      drop_cnt_q   <= 2'd0;
      line_drop_q  <= 1'b0;
      pix_valid_q  <= 1'b0;
    end else begin
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      bank_valid_q <= bank_valid_d;
      drop_cnt_q   <= drop_cnt_d;
      line_drop_q  <= line_drop_d;
      pix_valid_q  <= pix_valid_d;
    end
  end

  line_ram_2bank u_ram (
    .clk     (clk),
    .rst     (reset),
    .wr_en   (wr_accept),
    .wr_bank (eff_wr_bank),
    .wr_addr (bus.tia_xpos),
    .wr_data (bus.tia_color),
    .rd_en   (rd_en),
    .rd_bank (rd_bank_d),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign bus.pix_color      = rd_data;
  assign bus.pix_valid      = pix_valid_q;
  assign bus.line_drop      = line_drop_q;
  assign bus.dbg_wr_bank    = wr_bank_q;
  assign bus.dbg_rd_bank    = rd_bank_q;
  assign bus.dbg_bank_valid = bank_valid_q;

endmodule

// File: tb/tb_tia_scanline_doubler.sv
// Directed bench for the scanline doubler: ramp capture, held read bank, range guard,
// same-cycle line start + write, line-drop flag and mid-line reset.
module tb_tia_scanline_doubler;
  import atari_video_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  // Expected contents of the line the VGA side should currently be showing.
  logic [6:0] exp_line [0:159];
  logic       exp_valid;

  tia_scanline_doubler_if bus ();

  tia_scanline_doubler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus.tia_wr_en      = 1'b0;
    bus.tia_xpos       = 8'd0;
    bus.tia_color      = '0;
    bus.tia_line_start = 1'b0;
    bus.vga_line_start = 1'b0;
    bus.vga_hpos       = 10'd799;
    bus.vga_vpos       = 10'd1;
  endtask

  task automatic tia_pulse();
    bus.tia_line_start = 1'b1;
    step();
    bus.tia_line_start = 1'b0;
  endtask

  task automatic tia_write(input logic [7:0] x, input logic [6:0] c);
    bus.tia_wr_en = 1'b1;
    bus.tia_xpos  = x;
    bus.tia_color = c;
    step();
    bus.tia_wr_en = 1'b0;
  endtask

  // One full VGA line, every output compared against exp_line one cycle later.
  task automatic vga_sweep(input logic [9:0] v);
    logic [6:0] ec;
    logic       ev;
    for (int h = 0; h < 800; h++) begin
      bus.vga_hpos       = 10'(h);
      bus.vga_vpos       = v;
      bus.vga_line_start = (h == 0);
      step();
      ev = exp_valid && (h < 640);
      ec = ev ? exp_line[h / 4] : 7'd0;
      check($sformatf("pix_valid v%0d h%0d", v, h), {31'd0, bus.pix_valid}, {31'd0, ev});
      check($sformatf("pix_color v%0d h%0d", v, h), {25'd0, bus.pix_color}, {25'd0, ec});
    end
    bus.vga_line_start = 1'b0;
    bus.vga_hpos       = 10'd799;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] tmp;
    n_checks  = 0;
    n_fail    = 0;
    exp_valid = 1'b0;
    idle_inputs();

    reset = 1'b1;
    step();
    step();
    check("rst pix_valid", {31'd0, bus.pix_valid}, 32'd0);
    check("rst pix_color", {25'd0, bus.pix_color}, 32'd0);
    check("rst line_drop", {31'd0, bus.line_drop}, 32'd0);
    check("rst wr_bank", {31'd0, bus.dbg_wr_bank}, 32'd0);
    check("rst rd_bank", {31'd0, bus.dbg_rd_bank}, 32'd1);
    check("rst bank_valid", {30'd0, bus.dbg_bank_valid}, 32'd0);
    reset = 1'b0;

    // Nothing written: blank on even and odd lines.
    vga_sweep(10'd0);
    vga_sweep(10'd1);

    // Ramp line: colour = x truncated to 7 bits, so pixel 159 reads 0x1F.
    tia_pulse();
    for (int x = 0; x < 160; x++) begin
      tmp = 8'(x);
      tia_write(tmp, tmp[6:0]);
    end
    tia_pulse();
    for (int k = 0; k < 160; k++) begin
      tmp = 8'(k);
      exp_line[k] = tmp[6:0];
    end
    exp_valid = 1'b1;
    vga_sweep(10'd0);

    // New TIA line of 0x7F while the odd VGA line must keep the ramp.
    for (int x = 0; x < 160; x++) tia_write(8'(x), 7'h7F);
    vga_sweep(10'd1);
    tia_pulse();
    for (int k = 0; k < 160; k++) exp_line[k] = 7'h7F;
    vga_sweep(10'd2);

    // Pattern (3x+5)&0x7F, then out-of-range writes that must be dropped.
    for (int x = 0; x < 160; x++) begin
      tmp = 8'(3 * x + 5);
      tia_write(8'(x), tmp[6:0]);
    end
    tia_write(8'd160, 7'h55);
    tia_write(8'd200, 7'h55);
    tia_pulse();
    for (int k = 0; k < 160; k++) begin
      tmp = 8'(3 * k + 5);
      exp_line[k] = tmp[6:0];
    end
    vga_sweep(10'd4);
    check("oob pixel0", {25'd0, exp_line[0]}, 32'h05);
    check("oob pixel159", {25'd0, exp_line[159]}, 32'h62);

    // Line start and write in the same cycle: lands in the new bank (pattern bank).
    bus.tia_line_start = 1'b1;
    bus.tia_wr_en      = 1'b1;
    bus.tia_xpos       = 8'd0;
    bus.tia_color      = 7'h12;
    step();
    bus.tia_line_start = 1'b0;
    bus.tia_wr_en      = 1'b0;
    tia_pulse();
    exp_line[0] = 7'h12;
    vga_sweep(10'd6);
    check("drop after two pulses", {31'd0, bus.line_drop}, 32'd1);

    // Reset mid-line: blank and cleared flag on the next cycle.
    bus.vga_hpos = 10'd20;
    bus.vga_vpos = 10'd8;
    step();
    check("pre-reset pix_valid", {31'd0, bus.pix_valid}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("reset pix_valid", {31'd0, bus.pix_valid}, 32'd0);
    check("reset pix_color", {25'd0, bus.pix_color}, 32'd0);
    check("reset line_drop", {31'd0, bus.line_drop}, 32'd0);
    exp_valid = 1'b0;
    vga_sweep(10'd0);

    // Drop counter: cleared by an even latch, flag sets on the second pulse and sticks.
    tia_pulse();
    check("drop cnt1", {31'd0, bus.line_drop}, 32'd0);
    bus.vga_hpos       = 10'd0;
    bus.vga_vpos       = 10'd2;
    bus.vga_line_start = 1'b1;
    step();
    bus.vga_line_start = 1'b0;
    bus.vga_hpos       = 10'd799;
    tia_pulse();
    check("drop after latch", {31'd0, bus.line_drop}, 32'd0);
    tia_pulse();
    check("drop set", {31'd0, bus.line_drop}, 32'd1);
    tia_pulse();
    check("drop sticky", {31'd0, bus.line_drop}, 32'd1);
    bus.vga_hpos       = 10'd0;
    bus.vga_vpos       = 10'd4;
    bus.vga_line_start = 1'b1;
    step();
    bus.vga_line_start = 1'b0;
    check("drop sticky after latch", {31'd0, bus.line_drop}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
